// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder wrapper around fulladder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int SADD_MAX_WIDTH = 64;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder: A is the sum bit, cout the carry out.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic A,
  output logic cout
);

  assign A    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: shifts operands LSB-first through one fulladder,
// recirculating the carry, and returns {cout, sum} on an output handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output sadd_state_t      dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  sadd_state_t      state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic fa_x, fa_y, fa_cin, fa_a, fa_cout;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, and the
  // result stays frozen in DONE until out_ready is seen.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = (state_q == DONE) ? sum_sh_q : '0;
  assign cout      = (state_q == DONE) & carry_q;
  assign dbg_state = state_q;

  // Adder inputs are forced low outside RUN so the nets stay quiet.
  assign fa_x   = (state_q == RUN) & a_sh_q[0];
  assign fa_y   = (state_q == RUN) & b_sh_q[0];
  assign fa_cin = (state_q == RUN) & carry_q;

  fulladder u_fa (
    .x    (fa_x),
    .y    (fa_y),
    .cin  (fa_cin),
    .A    (fa_a),
    .cout (fa_cout)
  );

  always_comb begin
    sum_sh_d            = sum_sh_q >> 1;
    sum_sh_d[WIDTH-1]   = fa_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q   <= op_a;
            b_sh_q   <= op_b;
            carry_q  <= op_cin;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
